if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the MIPS 5-stage pipeline, directly upstream of the ID-stage controller.
- Owns the PC and talks to instruction memory over a req/ack handshake.
- Holds the IF/ID instruction register that drives the controller's inst input and if_valid.
- Obeys the controller's if_rst/if_en and takes branch/jump redirects from later stages.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset and after if_rst
NOP_INST, 32'h0000_0000, instruction word presented while if_valid=0

Ports:
clk  input  1  main clock
rst  input  1  asynchronous, active-low reset
if_rst  input  1  synchronous stage reset from controller
if_en  input  1  stage enable from controller; 0 = stall, IF/ID register holds
redirect_en  input  1  taken branch/jump, one-cycle pulse
redirect_pc  input  32  new fetch address
imem_req  output  1  instruction-memory request
imem_addr  output  32  word address of the request
imem_ack  input  1  memory data valid; may arrive in the same cycle as the req or later
imem_data  input  32  instruction word, valid with imem_ack
inst  output  32  IF/ID instruction to the controller
inst_pc  output  32  PC of inst
inst_pc_4  output  32  inst_pc+4, used for link
if_valid  output  1  inst is a real fetched instruction

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, inst=NOP_INST, inst_pc=0, inst_pc_4=0, if_valid=0, buffer empty.
- Priority, highest first: rst, then if_rst, then redirect_en, then normal flow.
- if_rst behaves as a redirect to RESET_PC. It also clears the IF/ID register regardless of if_en.
- FSM states:
  - IDLE: unconditionally go to REQ on the next edge.
  - REQ:
    - imem_req=1, imem_addr=pc.
    - imem_addr must be held stable until imem_ack.
    - On ack with if_en=1: load the IF/ID register {imem_data, pc, pc+4}, set if_valid=1, pc+=4, stay in REQ. Back-to-back fetching gives 1 instruction per cycle.
    - On ack with if_en=0: capture the word into the 1-entry buffer and go to HOLD.
  - HOLD:
    - imem_req=0.
    - On if_en=1: load the IF/ID register from the buffer, pc+=4, go to REQ.
  - DRAIN:
    - imem_req=1 with the old address, until ack.
    - The returning data is discarded; go to REQ with the redirected pc.
- IF/ID register updates:
  - When if_en=1 and no word is available this cycle: if_valid<=0 and inst<=NOP_INST (bubble).
  - When if_en=0: all IF/ID outputs hold.
- Redirect handling:
  - pc<=redirect_pc and the buffer is discarded.
  - In REQ without ack: go to DRAIN.
  - In REQ with ack in the same cycle: the data is dropped, go to REQ.
  - In HOLD: go to REQ.
  - The IF/ID register loads a bubble (if_valid=0) if if_en=1, else holds.
- Latency with a zero-wait memory: req in cycle 1 after rst release, if_valid=1 at the edge ending cycle 1.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.
- rst asserted mid-request: the state is abandoned immediately, and any late ack after release is ignored while in IDLE.

Optional Feature:
IF_ALIGN_CHECK_EN
- With the macro defined:
  - A redirect_pc with bits[1:0]!=0 sets a sticky output if_misaligned (1 bit, cleared by rst/if_rst).
  - No memory request is issued; the FSM parks in HOLD with an empty buffer, presenting bubbles until the next redirect or if_rst.
- Without the macro: the port is absent, and redirect_pc[1:0] are forced to 0.

Decomposition:
- Shared define header (the existing MIPS define include):
  - FSM state encoding {IDLE, REQ, HOLD, DRAIN}
  - NOP_INST value
  - RESET_PC default
- Sub-module if_fetch_buf: 1-entry holding register (data, pc, valid) with load/clear/drop.
- The top level keeps the FSM, PC and IF/ID register.

Test Plan:
- Zero-wait memory, if_en=1, RESET_PC=0 -> imem_addr 0,4,8,...; inst_pc follows one cycle later; if_valid=1 every cycle from cycle 2.
- imem_ack delayed 3 cycles per request -> imem_addr stable during the wait; if_valid=0 bubbles for 2 of every 3 cycles.
- if_en=0 for 4 cycles while an ack arrives -> FSM in HOLD, imem_req=0, outputs frozen; on if_en=1 the buffered word is presented with its correct pc.
- redirect_en with redirect_pc=32'h40 while a request to 8 is outstanding -> DRAIN until ack, data from 8 never reaches inst, next imem_addr=32'h40.
- redirect_en and if_rst in the same cycle -> pc=RESET_PC, if_valid=0; async rst low mid-REQ -> outputs reset immediately, not at the edge.
- With IF_ALIGN_CHECK_EN, redirect_pc=32'h42 -> if_misaligned=1, no imem_req; redirect_pc=32'h44 -> fetch resumes at 32'h44.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared MIPS fetch-stage state encoding, defaults and PC helper
package if_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// rtl/if_fetch_buf.sv - 1-entry holding register for a word fetched while the stage is stalled
module if_fetch_buf
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic        drop,
    input  logic [31:0] data_in,
    input  logic [31:0] pc_in,
    output logic [31:0] data,
    output logic [31:0] pc,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data  <= NOP_INST_DEF;
            pc    <= RESET_PC_DEF;
            valid <= 1'b0;
        end else if (drop) begin
            valid <= 1'b0;
        end else if (load) begin
            data  <= data_in;
            pc    <= pc_in;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS IF stage: PC, imem req/ack FSM, IF/ID register; optional IF_ALIGN_CHECK_EN
module if_fetch_stage
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_rst,
    input  logic        if_en,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_4,
`ifdef IF_ALIGN_CHECK_EN
    output logic        if_misaligned,
`endif
    output logic        if_valid
);

    fetch_state_t state, state_nx;
    logic [31:0]  pc, drain_addr, redir_target, redirect_pc_al;
    logic [31:0]  buf_data, buf_pc;
    logic         buf_valid;
    logic         redir, redir_bad, parked_d, ack_req, hold_rel, word_rdy;
    fetch_state_t redir_state;

    // if_rst is handled as a redirect to RESET_PC that also wins over redirect_en
    assign redir        = if_rst | redirect_en;
    assign redir_target = if_rst ? RESET_PC : redirect_pc_al;

`ifdef IF_ALIGN_CHECK_EN
    logic parked;

    assign redirect_pc_al = redirect_pc;
    assign redir_bad      = redirect_en & ~if_rst & (|redirect_pc[1:0]);
    assign parked_d       = redir ? redir_bad : parked;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parked        <= 1'b0;
            if_misaligned <= 1'b0;
        end else begin
            parked <= parked_d;
            if (if_rst)
                if_misaligned <= 1'b0;
            else if (redir_bad)
                if_misaligned <= 1'b1;
        end
    end
`else
    assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;
    assign redir_bad      = 1'b0;
    assign parked_d       = redir_bad;
`endif

    assign redir_state = parked_d ? HOLD : REQ;
    assign ack_req     = (state == REQ) & imem_ack;
    assign hold_rel    = (state == HOLD) & if_en & buf_valid;
    assign word_rdy    = ack_req | ((state == HOLD) & buf_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = redir ? redir_state : REQ;
            REQ: begin
                if (redir)
                    state_nx = imem_ack ? redir_state : DRAIN;
                else if (imem_ack && !if_en)
                    state_nx = HOLD;
            end
            HOLD: begin
                if (redir)
                    state_nx = redir_state;
                else if (hold_rel)
                    state_nx = REQ;
            end
            DRAIN: begin
                if (imem_ack)
                    state_nx = redir_state;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        case (state)
            REQ:   imem_req = 1'b1;
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
            end
            default: ;
        endcase
    end

    // drain_addr tracks the outstanding address so DRAIN keeps it stable after pc moves
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
        end else begin
            if (state == REQ)
                drain_addr <= pc;
            if (redir)
                pc <= redir_target;
            else if ((ack_req && if_en) || hold_rel)
                pc <= pc_next(pc);
        end
    end

    if_fetch_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (ack_req & ~if_en & ~redir),
        .clear   (hold_rel & ~redir),
        .drop    (redir),
        .data_in (imem_data),
        .pc_in   (pc),
        .data    (buf_data),
        .pc      (buf_pc),
        .valid   (buf_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst      <= NOP_INST;
            inst_pc   <= 32'd0;
            inst_pc_4 <= 32'd0;
            if_valid  <= 1'b0;
        end else if (if_rst) begin
            inst      <= NOP_INST;
            inst_pc   <= 32'd0;
            inst_pc_4 <= 32'd0;
            if_valid  <= 1'b0;
        end else if (if_en) begin
            if (redirect_en || !word_rdy) begin
                inst     <= NOP_INST;
                if_valid <= 1'b0;
            end else if (state == HOLD) begin
                inst      <= buf_data;
                inst_pc   <= buf_pc;
                inst_pc_4 <= pc_next(buf_pc);
                if_valid  <= 1'b1;
            end else begin
                inst      <= imem_data;
                inst_pc   <= pc;
                inst_pc_4 <= pc_next(pc);
                if_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

    logic        clk, rst, if_rst, if_en, redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_data;
    logic [31:0] inst, inst_pc, inst_pc_4;
    logic        if_valid;
    logic        ack_zero, ack_manual;
    int          n_assert = 0;
    int          n_fail   = 0;
`ifdef IF_ALIGN_CHECK_EN
    logic        if_misaligned;
`endif

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign imem_ack  = ack_zero ? imem_req : ack_manual;
    assign imem_data = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    if_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .if_rst      (if_rst),
        .if_en       (if_en),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_pc_4   (inst_pc_4),
`ifdef IF_ALIGN_CHECK_EN
        .if_misaligned (if_misaligned),
`endif
        .if_valid    (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; if_rst = 1'b0; if_en = 1'b1; redirect_en = 1'b0;
        redirect_pc = 32'd0; ack_zero = 1'b1; ack_manual = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_addr",  imem_addr, 32'd0);
        chk("rst_inst",  inst, 32'd0);
        chk("rst_pc",    inst_pc, 32'd0);
        chk("rst_pc4",   inst_pc_4, 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);

        // zero-wait streaming
        rst = 1'b1;
        @(negedge clk);
        chk("first_req",   32'(imem_req), 32'd1);
        chk("first_addr",  imem_addr, 32'd0);
        chk("first_valid", 32'(if_valid), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("stream_addr",  imem_addr, 32'(4 * k));
            chk("stream_pc",    inst_pc, 32'(4 * (k - 1)));
            chk("stream_inst",  inst, mem_word(32'(4 * (k - 1))));
            chk("stream_pc4",   inst_pc_4, 32'(4 * k));
            chk("stream_valid", 32'(if_valid), 32'd1);
        end

        // ack arrives on the third cycle of each request
        ack_zero = 1'b0; ack_manual = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 2; w++) begin
                @(negedge clk);
                chk("wait_addr",  imem_addr, 32'(16 + 4 * r));
                chk("wait_valid", 32'(if_valid), 32'd0);
            end
            ack_manual = 1'b1;
            @(negedge clk);
            ack_manual = 1'b0;
            chk("slow_pc",    inst_pc, 32'(16 + 4 * r));
            chk("slow_inst",  inst, mem_word(32'(16 + 4 * r)));
            chk("slow_valid", 32'(if_valid), 32'd1);
            chk("slow_addr",  imem_addr, 32'(20 + 4 * r));
        end

        // stall while the ack for 24 lands
        if_en = 1'b0; ack_manual = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ack_manual = 1'b0;
            chk("stall_req",   32'(imem_req), 32'd0);
            chk("stall_pc",    inst_pc, 32'd20);
            chk("stall_valid", 32'(if_valid), 32'd1);
        end
        if_en = 1'b1;
        @(negedge clk);
        chk("unstall_pc",    inst_pc, 32'd24);
        chk("unstall_inst",  inst, mem_word(32'd24));
        chk("unstall_pc4",   inst_pc_4, 32'd28);
        chk("unstall_valid", 32'(if_valid), 32'd1);
        chk("unstall_req",   32'(imem_req), 32'd1);
        chk("unstall_addr",  imem_addr, 32'd28);

        // redirect while request to 28 is outstanding
        redirect_en = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect_en = 1'b0;
        chk("drain_req",   32'(imem_req), 32'd1);
        chk("drain_addr",  imem_addr, 32'd28);
        chk("drain_valid", 32'(if_valid), 32'd0);
        @(negedge clk);
        chk("drain_addr2", imem_addr, 32'd28);
        ack_manual = 1'b1;
        @(negedge clk);
        ack_manual = 1'b0;
        chk("post_drain_addr",  imem_addr, 32'h40);
        chk("post_drain_valid", 32'(if_valid), 32'd0);
        chk("post_drain_inst",  inst, 32'd0);
        ack_zero = 1'b1;
        @(negedge clk);
        chk("redir_pc",    inst_pc, 32'h40);
        chk("redir_inst",  inst, mem_word(32'h40));
        chk("redir_valid", 32'(if_valid), 32'd1);

        // redirect coinciding with an ack
        redirect_en = 1'b1; redirect_pc = 32'h80;
        @(negedge clk);
        redirect_en = 1'b0;
        chk("redir_ack_valid", 32'(if_valid), 32'd0);
        chk("redir_ack_addr",  imem_addr, 32'h80);
        @(negedge clk);
        chk("redir_ack_pc",   inst_pc, 32'h80);
        chk("redir_ack_inst", inst, mem_word(32'h80));

        // PC wrap
        redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_en = 1'b0;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_pc",    inst_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4",   inst_pc_4, 32'd0);
        chk("wrap_addr1", imem_addr, 32'd0);

        // misaligned redirect target
        redirect_en = 1'b1; redirect_pc = 32'h42;
        @(negedge clk);
        redirect_en = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        chk("misal_flag", 32'(if_misaligned), 32'd1);
        chk("misal_req",  32'(imem_req), 32'd0);
        @(negedge clk);
        chk("misal_park", 32'(imem_req), 32'd0);
        redirect_en = 1'b1; redirect_pc = 32'h44;
        @(negedge clk);
        redirect_en = 1'b0;
        chk("misal_resume_addr", imem_addr, 32'h44);
        chk("misal_resume_req",  32'(imem_req), 32'd1);
        chk("misal_sticky",      32'(if_misaligned), 32'd1);
        @(negedge clk);
        chk("misal_fetch_pc", inst_pc, 32'h44);
`else
        chk("align_force_addr", imem_addr, 32'h40);
        @(negedge clk);
        chk("align_force_pc",    inst_pc, 32'h40);
        chk("align_force_valid", 32'(if_valid), 32'd1);
`endif

        // if_rst beats a simultaneous redirect
        if_rst = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        if_rst = 1'b0; redirect_en = 1'b0;
        chk("ifrst_addr",  imem_addr, 32'd0);
        chk("ifrst_valid", 32'(if_valid), 32'd0);
        chk("ifrst_pc",    inst_pc, 32'd0);
        chk("ifrst_pc4",   inst_pc_4, 32'd0);
`ifdef IF_ALIGN_CHECK_EN
        chk("ifrst_misal", 32'(if_misaligned), 32'd0);
`endif
        @(negedge clk);
        chk("ifrst_fetch_valid", 32'(if_valid), 32'd1);
        chk("ifrst_fetch_pc4",   inst_pc_4, 32'd4);

        // async reset mid-request, late ack ignored
        ack_zero = 1'b0; ack_manual = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_valid", 32'(if_valid), 32'd0);
        chk("async_req",   32'(imem_req), 32'd0);
        chk("async_pc4",   inst_pc_4, 32'd0);
        chk("async_inst",  inst, 32'd0);
        ack_manual = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("late_ack_req",   32'(imem_req), 32'd1);
        chk("late_ack_addr",  imem_addr, 32'd0);
        chk("late_ack_valid", 32'(if_valid), 32'd0);
        ack_manual = 1'b0; ack_zero = 1'b1;
        @(negedge clk);
        chk("restart_valid", 32'(if_valid), 32'd1);
        chk("restart_inst",  inst, mem_word(32'd0));
        chk("restart_addr",  imem_addr, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
